// File: rtl/xor_response_checker.sv
// Checks out == in1 ^ in2 on every valid cycle of a run, counting vectors, errors and idle cycles.
// Counters update on the sampling edge (no pipeline); the unit never stalls its source, and valid is ignored outside CHECK.
module xor_response_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             in1,
  input  logic             in2,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idle_cnt;
  logic            mismatch;
  logic [CNT_W-1:0] vec_inc;
  logic [CNT_W-1:0] err_next;
  logic            last_vec;
  logic            idle_expire;

  always_comb begin
    mismatch    = out != (in1 ^ in2);
    vec_inc     = vec_count + 1'b1;
    err_next    = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;
    last_vec    = vec_inc == CNT_W'(NUM_VECTORS);
    idle_expire = idle_cnt == IW'(TIMEOUT - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      timeout          <= 1'b0;
      vec_count        <= '0;
      err_count        <= '0;
      idle_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_vec   <= 3'b000;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Status stays frozen until the next start arms a fresh run.
          if (start) begin
            state            <= CHECK;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            vec_count        <= '0;
            err_count        <= '0;
            idle_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_vec   <= 3'b000;
          end
        end
        CHECK: begin
          if (valid) begin
            vec_count <= vec_inc;
            err_count <= err_next;
            idle_cnt  <= '0;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_count;
              first_fail_vec   <= {in1, in2, out};
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0) && !timeout;
            end
          end else if (idle_expire) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
